// File: rtl/gate_checker_if.sv
// Gate self-test bus: the gate stimulus/response pair plus the run
// control and result signals of the checker.
//
// master : the checker (drives a_drv/b_drv and the results, samples
//          start and the seven gate responses)
// slave  : the surrounding system / gate under test
interface gate_checker_if;

    // Run control
    logic       start;
    logic       busy;
    logic       done;

    // Gate stimulus
    logic       a_drv;
    logic       b_drv;

    // Gate responses under test
    logic       and_in;
    logic       or_in;
    logic       not_in;
    logic       nand_in;
    logic       nor_in;
    logic       xor_in;
    logic       xnor_in;

    // Run results
    logic       pass;
    logic [6:0] fail_vec;
    logic [4:0] err_count;
    logic       first_fail_vld;
    logic [1:0] first_fail_idx;

    modport master (
        input  start,
        input  and_in, or_in, not_in, nand_in, nor_in, xor_in, xnor_in,
        output busy, done,
        output a_drv, b_drv,
        output pass, fail_vec, err_count, first_fail_vld, first_fail_idx
    );

    modport slave (
        output start,
        output and_in, or_in, not_in, nand_in, nor_in, xor_in, xnor_in,
        input  busy, done,
        input  a_drv, b_drv,
        input  pass, fail_vec, err_count, first_fail_vld, first_fail_idx
    );

endinterface

// File: rtl/gate_checker.sv
// Self-test engine for the two-input logic-gate block. Walks the gate
// inputs through {a,b} = 00, 01, 10, 11, lets each vector settle for
// SETTLE_CYCLES cycles, then compares the seven gate responses with the
// truth table and accumulates per-gate flags, a mismatch count and the
// index of the first failing vector.
//
// Run handshake: start is a level request that is looked at only while
// the engine is idle (busy low). An accepted start clears all results,
// raises busy from the next cycle, and ends with exactly one done pulse
// (busy still high in that cycle) carrying final pass/err_count. start
// seen while busy is ignored; start held high re-launches a run in the
// first idle cycle after done. Reset aborts a run silently (no done).
module gate_checker #(
    parameter int unsigned SETTLE_CYCLES = 2   // legal range 1..15
) (
    input  logic             clk,
    input  logic             rst,
    gate_checker_if.master   bus,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Counter reload value: SETTLE lasts cnt+1 cycles, counting down to 0.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [1:0] LAST_IDX    = 2'd3;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t     state_q;
    logic [1:0] idx_q;          // current vector; also drives a/b directly
    logic [3:0] cnt_q;          // settle countdown
    logic [6:0] fail_vec_q;
    logic [4:0] err_count_q;
    logic       pass_q;
    logic       ff_vld_q;
    logic [1:0] ff_idx_q;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t     state_n;
    logic [1:0] idx_n;
    logic [3:0] cnt_n;
    logic [6:0] fail_vec_n;
    logic [4:0] err_count_n;
    logic       pass_n;
    logic       ff_vld_n;
    logic [1:0] ff_idx_n;

    // ------------------------------------------------------------------
    // Compare datapath
    // ------------------------------------------------------------------
    logic       vec_a;
    logic       vec_b;
    logic [6:0] exp_vec;        // truth-table response for the current vector
    logic [6:0] resp_vec;       // observed gate response
    logic [6:0] mis_vec;        // one bit per gate that disagrees
    logic [2:0] mis_cnt;        // popcount of mis_vec (0..7)

    // Expected gate outputs for the vector currently being driven
    always_comb begin
        vec_a   = idx_q[1];
        vec_b   = idx_q[0];
        exp_vec = 7'd0;
        exp_vec[0] = vec_a & vec_b;        // and
        exp_vec[1] = vec_a | vec_b;        // or
        exp_vec[2] = ~vec_a;               // not (of a)
        exp_vec[3] = ~(vec_a & vec_b);     // nand
        exp_vec[4] = ~(vec_a | vec_b);     // nor
        exp_vec[5] = vec_a ^ vec_b;        // xor
        exp_vec[6] = ~(vec_a ^ vec_b);     // xnor
    end

    // Gather responses in fail_vec bit order and count disagreeing gates
    always_comb begin
        resp_vec = {bus.xnor_in, bus.xor_in, bus.nor_in, bus.nand_in,
                    bus.not_in, bus.or_in, bus.and_in};
        mis_vec  = exp_vec ^ resp_vec;
        mis_cnt  = 3'd0;
        for (int i = 0; i < 7; i++) begin
            mis_cnt = mis_cnt + {2'b00, mis_vec[i]};
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and result update
    // ------------------------------------------------------------------
    // Sequencing and result accumulation; every register holds by default
    always_comb begin
        state_n     = state_q;
        idx_n       = idx_q;
        cnt_n       = cnt_q;
        fail_vec_n  = fail_vec_q;
        err_count_n = err_count_q;
        pass_n      = pass_q;
        ff_vld_n    = ff_vld_q;
        ff_idx_n    = ff_idx_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    // Results of the previous run stay visible until here
                    fail_vec_n  = 7'd0;
                    err_count_n = 5'd0;
                    pass_n      = 1'b0;
                    ff_vld_n    = 1'b0;
                    ff_idx_n    = 2'd0;
                    idx_n       = 2'd0;
                    cnt_n       = SETTLE_LOAD;
                    state_n     = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_n = ST_CHECK;
                end else begin
                    cnt_n = cnt_q - 4'd1;
                end
            end

            ST_CHECK: begin
                fail_vec_n  = fail_vec_q | mis_vec;
                err_count_n = err_count_q + {2'b00, mis_cnt};
                if ((mis_vec != 7'd0) && !ff_vld_q) begin
                    ff_vld_n = 1'b1;
                    ff_idx_n = idx_q;
                end
                if (idx_q == LAST_IDX) begin
                    // pass is registered on entry to DONE so it is valid
                    // in the same cycle as the done pulse, and it already
                    // includes this final vector's mismatches
                    pass_n  = (err_count_n == 5'd0) && (fail_vec_n == 7'd0);
                    state_n = ST_DONE;
                end else begin
                    idx_n   = idx_q + 2'd1;
                    cnt_n   = SETTLE_LOAD;
                    state_n = ST_SETTLE;
                end
            end

            ST_DONE: begin
                // idx stays at 3, so a/b keep driving (1,1) while idle
                state_n = ST_IDLE;
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and result registers; reset aborts any run in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= 2'd0;
            cnt_q       <= 4'd0;
            fail_vec_q  <= 7'd0;
            err_count_q <= 5'd0;
            pass_q      <= 1'b0;
            ff_vld_q    <= 1'b0;
            ff_idx_q    <= 2'd0;
        end else begin
            state_q     <= state_n;
            idx_q       <= idx_n;
            cnt_q       <= cnt_n;
            fail_vec_q  <= fail_vec_n;
            err_count_q <= err_count_n;
            pass_q      <= pass_n;
            ff_vld_q    <= ff_vld_n;
            ff_idx_q    <= ff_idx_n;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all decoded from registers, no combinational input paths)
    // ------------------------------------------------------------------
    // Drive, status and result outputs
    always_comb begin
        bus.a_drv          = idx_q[1];
        bus.b_drv          = idx_q[0];
        bus.busy           = (state_q != ST_IDLE);
        bus.done           = (state_q == ST_DONE);
        bus.pass           = pass_q;
        bus.fail_vec       = fail_vec_q;
        bus.err_count      = err_count_q;
        bus.first_fail_vld = ff_vld_q;
        bus.first_fail_idx = ff_idx_q;
        dbg_state          = state_q;
    end

endmodule
